// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: default 640x480 timing,
// pattern mode encodings and the colour-bar table.
package vga_pkg;

    localparam int unsigned HActiveDef = 640;
    localparam int unsigned HFpDef     = 16;
    localparam int unsigned HSyncDef   = 96;
    localparam int unsigned HBpDef     = 48;
    localparam int unsigned VActiveDef = 480;
    localparam int unsigned VFpDef     = 10;
    localparam int unsigned VSyncDef   = 2;
    localparam int unsigned VBpDef     = 33;
    localparam int unsigned ClkDivDef  = 2;
    localparam int unsigned ColorWDef  = 8;

    // Counter width; covers totals up to 4095 pixels or lines.
    localparam int unsigned CntW = 12;

    typedef enum logic [1:0] {
        ModeExt      = 2'd0,
        ModeBars     = 2'd1,
        ModeChecker  = 2'd2,
        ModeGradient = 2'd3
    } mode_e;

    // {r,g,b} on/off per bar, index 0 at the left edge:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BarTable = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video port bundle: external pixel source and mode in, timing/colour out.
// The generator uses the master modport, a display sink the slave modport.
interface vga_timing_gen_if #(
    parameter int unsigned COLOR_W = 8
);
    logic [1:0]         mode;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;
    logic               pix_ce;
    logic [9:0]         x;
    logic [9:0]         y;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               frame_start;

    modport master (
        input  mode, pix_r, pix_g, pix_b,
        output pix_ce, x, y, hsync, vsync, de, r, g, b, frame_start
    );

    modport slave (
        output mode, pix_r, pix_g, pix_b,
        input  pix_ce, x, y, hsync, vsync, de, r, g, b, frame_start
    );
endinterface

// File: rtl/vga_pattern.sv
// Combinational test-pattern source (bars, checker, gradient) driven by the
// stage-1 pixel coordinate; returns black for the external mode.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = HActiveDef,
    parameter int unsigned COLOR_W  = ColorWDef
) (
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);
    logic [2:0]         bar_idx;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] grad_r;
    logic [COLOR_W-1:0] grad_g;
    logic               unused_xy;

    // x < H_ACTIVE in the active area, so the quotient always fits 0..7.
    assign bar_idx   = 3'((32'(x) << 3) / H_ACTIVE);
    assign bar       = BarTable[bar_idx];
    assign unused_xy = ^{x, y};

    if (COLOR_W <= 10) begin : g_grad_msb
        assign grad_r = x[9 -: COLOR_W];
        assign grad_g = y[9 -: COLOR_W];
    end else begin : g_grad_ext
        assign grad_r = COLOR_W'(x);
        assign grad_g = COLOR_W'(y);
    end

    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        case (mode_e'(mode))
            ModeBars: begin
                r = {COLOR_W{bar[2]}};
                g = {COLOR_W{bar[1]}};
                b = {COLOR_W{bar[0]}};
            end
            ModeChecker: begin
                if (x[5] ^ y[5]) begin
                    r = '1;
                    g = '1;
                    b = '1;
                end
            end
            ModeGradient: begin
                r = grad_r;
                g = grad_g;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters, two-stage output pipeline.
// Define VGA_PATTERN_EN to build the internal test-pattern source (modes 1-3).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = HActiveDef,
    parameter int unsigned H_FP     = HFpDef,
    parameter int unsigned H_SYNC   = HSyncDef,
    parameter int unsigned H_BP     = HBpDef,
    parameter int unsigned V_ACTIVE = VActiveDef,
    parameter int unsigned V_FP     = VFpDef,
    parameter int unsigned V_SYNC   = VSyncDef,
    parameter int unsigned V_BP     = VBpDef,
    parameter int unsigned CLK_DIV  = ClkDivDef,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = ColorWDef
) (
    input logic              clk_master,
    input logic              rst,
    vga_timing_gen_if.master vid
);
    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] HLast   = CntW'(HTotal - 1);
    localparam logic [CntW-1:0] VLast   = CntW'(VTotal - 1);
    localparam logic [CntW-1:0] HAct    = CntW'(H_ACTIVE);
    localparam logic [CntW-1:0] VAct    = CntW'(V_ACTIVE);
    localparam logic [CntW-1:0] HsBeg   = CntW'(H_ACTIVE + H_FP);
    localparam logic [CntW-1:0] HsEnd   = CntW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CntW-1:0] VsBeg   = CntW'(V_ACTIVE + V_FP);
    localparam logic [CntW-1:0] VsEnd   = CntW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DivW-1:0]    div_q;
    logic               tick;
    logic               frame_tick;
    logic [CntW-1:0]    h_q;
    logic [CntW-1:0]    v_q;
    logic               active;
    logic [9:0]         x_q;
    logic [9:0]         y_q;
    logic               de1_q;
    logic               hs1_q;
    logic               vs1_q;
    logic               de_q;
    logic               hsync_q;
    logic               vsync_q;
    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;
    logic [COLOR_W-1:0] r_q;
    logic [COLOR_W-1:0] g_q;
    logic [COLOR_W-1:0] b_q;

    assign tick       = (div_q == DivLast);
    assign frame_tick = tick && (h_q == '0) && (v_q == '0);
    assign active     = (h_q < HAct) && (v_q < VAct);

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (tick) begin
            if (h_q == HLast) begin
                h_q <= '0;
                v_q <= (v_q == VLast) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    // Stage 1: coordinate plus early enable and sync windows of the counter value.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            de1_q <= 1'b0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
        end else if (tick) begin
            x_q   <= active ? h_q[9:0] : '0;
            y_q   <= active ? v_q[9:0] : '0;
            de1_q <= active;
            hs1_q <= (h_q >= HsBeg) && (h_q < HsEnd);
            vs1_q <= (v_q >= VsBeg) && (v_q < VsEnd);
        end
    end

`ifdef VGA_PATTERN_EN
    logic [1:0]         mode_q;
    logic [COLOR_W-1:0] pat_r;
    logic [COLOR_W-1:0] pat_g;
    logic [COLOR_W-1:0] pat_b;

    // Mode only changes on the first pixel of a frame, so a frame never mixes modes.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            mode_q <= ModeExt;
        end else if (frame_tick) begin
            mode_q <= vid.mode;
        end
    end

    vga_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .COLOR_W  (COLOR_W)
    ) u_pattern (
        .x    (x_q),
        .y    (y_q),
        .mode (mode_q),
        .r    (pat_r),
        .g    (pat_g),
        .b    (pat_b)
    );

    assign src_r = (mode_q == ModeExt) ? vid.pix_r : pat_r;
    assign src_g = (mode_q == ModeExt) ? vid.pix_g : pat_g;
    assign src_b = (mode_q == ModeExt) ? vid.pix_b : pat_b;
`else
    logic unused_mode;

    assign unused_mode = ^vid.mode;
    assign src_r       = vid.pix_r;
    assign src_g       = vid.pix_g;
    assign src_b       = vid.pix_b;
`endif

    // Stage 2: pixel data arriving now belongs to the x/y registered in stage 1.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else if (tick) begin
            de_q    <= de1_q;
            hsync_q <= hs1_q ? HS_POL : ~HS_POL;
            vsync_q <= vs1_q ? VS_POL : ~VS_POL;
            r_q     <= de1_q ? src_r : '0;
            g_q     <= de1_q ? src_g : '0;
            b_q     <= de1_q ? src_b : '0;
        end
    end

    // Strobes are forced low while reset is held (CLK_DIV=1 would otherwise tick).
    assign vid.pix_ce      = tick & ~rst;
    assign vid.frame_start = frame_tick & ~rst;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.de          = de_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.r           = r_q;
    assign vid.g           = g_q;
    assign vid.b           = b_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, the vertical equivalents in lines.
REQ-004 SHALL have parameter CLK_DIV, default 2, clk_master cycles per pixel (legal range 1..16).
REQ-005 SHALL have parameters HS_POL, VS_POL, default 0, asserted sync levels.
REQ-006 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-007 clk_master  in  1  sole clock.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 mode  in  2  pattern select: 0 external, 1 bars, 2 checker, 3 gradient.
REQ-010 pix_r, pix_g, pix_b  in  COLOR_W each  external pixel data for the x/y presented one pixel earlier.
REQ-011 pix_ce  out  1  one-cycle pixel strobe.
REQ-012 x, y  out  10 each  coordinate of next pixel, 0 outside active area.
REQ-013 hsync, vsync  out  1 each  sync outputs.
REQ-014 de  out  1  data enable, aligned with r/g/b.
REQ-015 r, g, b  out  COLOR_W each  pixel colour.
REQ-016 frame_start  out  1  one-cycle pulse at each frame start.

Function
REQ-017 Divider counts 0..CLK_DIV-1 on clk_master and SHALL drive pix_ce high in the cycle the divider equals CLK_DIV-1; CLK_DIV=1 gives pix_ce constantly high.
REQ-018 h_count SHALL advance on pix_ce only, wrapping from H_TOTAL-1 to 0, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-019 v_count SHALL advance when h_count wraps, wrapping from V_TOTAL-1 to 0.
REQ-020 Line order SHALL be active, front porch, sync, back porch; the frame has the same order.
REQ-021 Stage 1, registered on pix_ce, SHALL output x/y = counters when both are in active range, else 0, and an internal early enable.
REQ-022 Stage 2, registered on pix_ce, SHALL produce de, hsync, vsync and r/g/b, so that sync and colour lag the counters by 2 pixels and lag x/y by 1 pixel.
REQ-023 hsync SHALL equal HS_POL while the delayed h_count is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL; vsync is defined likewise with VS_POL.
REQ-024 r/g/b SHALL be 0 whenever de=0.
REQ-025 mode SHALL be latched only when pix_ce=1 with h_count=0 and v_count=0, so that a change mid-frame applies from the next frame.
REQ-026 frame_start SHALL pulse for exactly one clk_master cycle, coincident with the pix_ce on which mode is latched.
REQ-027 Mode 1 SHALL draw 8 equal bars, index = x*8/H_ACTIVE, in the order white, yellow, cyan, green, magenta, red, blue, black, with each channel at full scale or 0.
REQ-028 Mode 2 SHALL draw white when x[5]^y[5] is set and black otherwise.
REQ-029 Mode 3 SHALL set r = x[9:10-COLOR_W] (zero-extended if COLOR_W>10), g = y likewise, and b = 0.

Reset
REQ-030 While rst is high, divider, h_count, v_count, x, y, de, r, g, b, pix_ce, frame_start and the mode latch SHALL be 0, and hsync/vsync SHALL be at their deasserted levels.
REQ-031 On rst deassertion mid-frame, timing SHALL restart at h_count=v_count=0, with the first frame_start on the first pix_ce.

Configuration
REQ-032 With VGA_PATTERN_EN defined, modes 1-3 SHALL be generated as specified.
REQ-033 Without VGA_PATTERN_EN, every mode SHALL behave as mode 0 and no pattern logic SHALL be synthesised.

Structure
REQ-034 Package vga_pkg SHALL hold the default 640x480 timing constants, the mode encodings and the bar colour table.
REQ-035 The pattern logic SHALL be sub-module vga_pattern (inputs x, y, mode; outputs combinational rgb), instantiated only under VGA_PATTERN_EN.

Verification
REQ-036 Default parameters, mode 0 -> hsync low for 192 clk_master cycles, line period 1600 cycles, vsync low for 2 lines, frame period 840000 cycles.
REQ-037 pix_r=8'hAA, pix_g=8'h55, pix_b=8'h0F constant -> r/g/b equal these values exactly when de=1, 0 otherwise, de high for 640 pixels x 480 lines.
REQ-038 mode=1 -> pixel x=0 is FFFFFF, x=80 is FFFF00, x=639 is 000000.
REQ-039 mode switched from 0 to 2 at line 100 -> no change until the next frame_start, then (x=32, y=0) is white and (x=32, y=32) is black.
REQ-040 rst pulsed at h_count=300, v_count=200 -> outputs at reset values during the pulse, then first frame_start on the first pix_ce after release.
REQ-041 CLK_DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> pix_ce constantly high, line period 14 cycles, frame period 98 cycles.
